lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit sitting directly downstream of the issue stage; consumes its data request, write-enable, store data and destination register, plus the ALU-computed address.
- Drives a req/gnt/rvalid data-memory port, formats byte/half/word accesses, and produces the register-file write for loads.
- One access in flight at a time; issue must wait on lsu_ready_o.

Parameters:
- ADDR_W, 32, data-memory address width.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- lsu_req_i  in  1  access request from issue (data_req_o of issue).
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_type_i  in  2  00 word, 01 half, 10 byte, 11 illegal.
- lsu_sign_ext_i  in  1  sign-extend load result.
- lsu_addr_i  in  ADDR_W  byte address from ALU.
- lsu_wdata_i  in  32  store data, right-aligned.
- lsu_rd_i  in  5  destination register for loads.
- lsu_ready_o  out  1  LSU can accept a request.
- lsu_done_o  out  1  one-cycle pulse when an access completes or fails.
- lsu_err_o  out  1  one-cycle pulse, coincident with done, on failure.
- data_req_o  out  1  memory request.
- data_gnt_i  in  1  memory grant.
- data_rvalid_i  in  1  response valid.
- data_err_i  in  1  bus error, sampled with rvalid.
- data_addr_o  out  ADDR_W  word-aligned address (addr[1:0] = 00).
- data_we_o  out  1  write enable.
- data_be_o  out  4  byte enables.
- data_wdata_o  out  32  lane-shifted store data.
- data_rdata_i  in  32  load data.
- rf_we_o  out  1  register-file write strobe.
- rf_waddr_o  out  5  register-file write address.
- rf_wdata_o  out  32  register-file write data.

Behaviour:
- Reset (rst_ni low at an edge): state IDLE. All outputs 0 except lsu_ready_o = 1; timeout counter cleared.
- FSM states:
  - IDLE: lsu_ready_o = 1.
  - WAIT_GNT: lsu_ready_o = 0.
  - WAIT_RVALID: lsu_ready_o = 0.
- Accept: lsu_req_i && lsu_ready_o at an edge. Latch we, type, sign_ext, rd and addr[1:0].
- Misalignment/illegal check at accept. Any of these is an error:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - type 11.
- On error: no memory request; next cycle lsu_done_o = lsu_err_o = 1; stay in IDLE.
- Otherwise, go to WAIT_GNT and drive data_req_o = 1 starting the cycle after accept.
- Byte enables and data:
  - word: be = 1111.
  - half: be = 0011 << addr[1:0].
  - byte: be = 0001 << addr[1:0].
  - data_wdata_o = lsu_wdata_i << (8 * addr[1:0]).
- WAIT_GNT:
  - req, addr, we, be and wdata are held stable until data_gnt_i is sampled high.
  - On gnt: data_req_o drops at that edge; go to WAIT_RVALID.
  - data_rvalid_i in this state is ignored.
- WAIT_RVALID, on data_rvalid_i:
  - Go to IDLE.
  - Next cycle lsu_done_o = 1.
  - If data_err_i: also lsu_err_o = 1, and no rf write.
  - Else for a load: rf_we_o = 1 for one cycle (same cycle as done), with rf_waddr_o = latched rd.
  - rf_wdata_o = (data_rdata_i >> (8 * addr[1:0])), truncated to 8/16 bits, then zero- or sign-extended per sign_ext.
  - Stores never assert rf_we_o.
- Load to rd = 0: done pulses, rf_we_o stays 0.
- New request accepted in the same cycle done pulses (IDLE re-entered): allowed, giving back-to-back throughput of one access per 3 cycles minimum.
- Reset mid-access: abort, go to IDLE, data_req_o = 0. A late rvalid arriving in IDLE is ignored, with no done or rf write.
- rf_waddr_o and rf_wdata_o hold their last value when rf_we_o = 0.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_GNT and increments each cycle in WAIT_GNT/WAIT_RVALID.
  - When it reaches TIMEOUT_CYCLES: data_req_o = 0, go to IDLE, and next cycle lsu_done_o = lsu_err_o = 1.
  - A subsequent stale rvalid is ignored.
- Undefined: no counter; the LSU waits indefinitely for gnt/rvalid.

Test Plan:
- Word store: addr 0x100, wdata 0xDEADBEEF, gnt same cycle as req, rvalid next cycle -> data_addr_o 0x100, be 1111, wdata 0xDEADBEEF; done once, rf_we_o never 1.
- Signed byte load: addr 0x203, rdata 0x80FFFFFF, rd 5 -> be 1000; rf_we_o = 1, rf_waddr_o 5, rf_wdata_o 0xFFFFFF80.
- Unsigned half load: addr 0x202, rdata 0xBEEF1234 -> be 1100, rf_wdata_o 0x0000BEEF.
- Misaligned word load: addr 0x101 -> data_req_o stays 0; done + err pulse the cycle after accept; no rf write.
- gnt delayed 3 cycles with wdata changing on inputs -> req/addr/be/wdata held constant all 3 cycles; req drops after gnt.
- rst_ni low while in WAIT_RVALID, then rvalid asserted -> IDLE, no done, no rf_we_o. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4, gnt never given -> err + done after 4 cycles.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit: one access in flight on a req/gnt/rvalid data port, with byte/half/word
// lane formatting and register-file writeback. Optional watchdog: define LSU_TIMEOUT_EN.
module lsu_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [1:0]        lsu_type_i,
  input  logic              lsu_sign_ext_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  input  logic [4:0]        lsu_rd_i,
  output logic              lsu_ready_o,
  output logic              lsu_done_o,
  output logic              lsu_err_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic              data_err_i,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [31:0]       data_wdata_o,
  input  logic [31:0]       data_rdata_i,
  output logic              rf_we_o,
  output logic [4:0]        rf_waddr_o,
  output logic [31:0]       rf_wdata_o,
  output logic [1:0]        dbg_state_o
);

  // Handshake: issue transfers when lsu_req_i && lsu_ready_o at a rising edge; the memory
  // request is held with stable attributes until data_gnt_i is sampled high, and exactly one
  // data_rvalid_i per granted request is consumed in WAIT_RVALID.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } state_t;

  state_t      state;
  logic        we_q;
  logic [1:0]  type_q;
  logic        sext_q;
  logic [4:0]  rd_q;
  logic [1:0]  off_q;

  logic        acc_err;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] rshift;
  logic [31:0] rf_next;
  logic        tmo_hit;

  assign dbg_state_o = state;
  assign lsu_ready_o = (state == IDLE);

  // Alignment check and lane placement for the request being offered.
  always_comb begin
    acc_err = 1'b0;
    be_next = 4'b1111;
    case (lsu_type_i)
      2'b00: begin
        be_next = 4'b1111;
        acc_err = (lsu_addr_i[1:0] != 2'b00);
      end
      2'b01: begin
        be_next = 4'b0011 << lsu_addr_i[1:0];
        acc_err = lsu_addr_i[0];
      end
      2'b10: begin
        be_next = 4'b0001 << lsu_addr_i[1:0];
        acc_err = 1'b0;
      end
      default: begin
        be_next = 4'b0000;
        acc_err = 1'b1;
      end
    endcase
  end

  assign wdata_next = lsu_wdata_i << {lsu_addr_i[1:0], 3'b000};

  // Load data is shifted down to bit 0 before truncation and extension.
  assign rshift = data_rdata_i >> {off_q, 3'b000};

  always_comb begin
    rf_next = rshift;
    case (type_q)
      2'b10:   rf_next = sext_q ? {{24{rshift[7]}}, rshift[7:0]} : {24'h0, rshift[7:0]};
      2'b01:   rf_next = sext_q ? {{16{rshift[15]}}, rshift[15:0]} : {16'h0, rshift[15:0]};
      default: rf_next = rshift;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Held at zero in IDLE, so it starts from zero on every entry to WAIT_GNT.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      type_q       <= 2'b00;
      sext_q       <= 1'b0;
      rd_q         <= 5'd0;
      off_q        <= 2'b00;
      lsu_done_o   <= 1'b0;
      lsu_err_o    <= 1'b0;
      data_req_o   <= 1'b0;
      data_addr_o  <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'b0000;
      data_wdata_o <= 32'h0;
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= 5'd0;
      rf_wdata_o   <= 32'h0;
    end else begin
      lsu_done_o <= 1'b0;
      lsu_err_o  <= 1'b0;
      rf_we_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_req_i) begin
            we_q   <= lsu_we_i;
            type_q <= lsu_type_i;
            sext_q <= lsu_sign_ext_i;
            rd_q   <= lsu_rd_i;
            off_q  <= lsu_addr_i[1:0];
            if (acc_err) begin
              lsu_done_o <= 1'b1;
              lsu_err_o  <= 1'b1;
            end else begin
              state        <= WAIT_GNT;
              data_req_o   <= 1'b1;
              data_addr_o  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
              data_we_o    <= lsu_we_i;
              data_be_o    <= be_next;
              data_wdata_o <= wdata_next;
            end
          end
        end
        WAIT_GNT: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            state      <= WAIT_RVALID;
          end else if (tmo_hit) begin
            data_req_o <= 1'b0;
            state      <= IDLE;
            lsu_done_o <= 1'b1;
            lsu_err_o  <= 1'b1;
          end
        end
        WAIT_RVALID: begin
          if (data_rvalid_i) begin
            state      <= IDLE;
            lsu_done_o <= 1'b1;
            lsu_err_o  <= data_err_i;
            // rd 0 is hardwired zero in the register file, so it never gets a write.
            if (!data_err_i && !we_q && (rd_q != 5'd0)) begin
              rf_we_o    <= 1'b1;
              rf_waddr_o <= rd_q;
              rf_wdata_o <= rf_next;
            end
          end else if (tmo_hit) begin
            state      <= IDLE;
            lsu_done_o <= 1'b1;
            lsu_err_o  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          data_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads, stores, alignment errors, grant stalls and reset abort.
// Expected register-file writes are queued and matched by a monitor on the falling edge.
module tb_lsu_ctrl;

  localparam int ADDR_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              lsu_req_i = 1'b0;
  logic              lsu_we_i = 1'b0;
  logic [1:0]        lsu_type_i = 2'b00;
  logic              lsu_sign_ext_i = 1'b0;
  logic [ADDR_W-1:0] lsu_addr_i = '0;
  logic [31:0]       lsu_wdata_i = 32'h0;
  logic [4:0]        lsu_rd_i = 5'd0;
  logic              lsu_ready_o;
  logic              lsu_done_o;
  logic              lsu_err_o;
  logic              data_req_o;
  logic              data_gnt_i = 1'b0;
  logic              data_rvalid_i = 1'b0;
  logic              data_err_i = 1'b0;
  logic [ADDR_W-1:0] data_addr_o;
  logic              data_we_o;
  logic [3:0]        data_be_o;
  logic [31:0]       data_wdata_o;
  logic [31:0]       data_rdata_i = 32'h0;
  logic              rf_we_o;
  logic [4:0]        rf_waddr_o;
  logic [31:0]       rf_wdata_o;
  logic [1:0]        dbg_state_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  lsu_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_rd_i(lsu_rd_i), .lsu_ready_o(lsu_ready_o), .lsu_done_o(lsu_done_o),
    .lsu_err_o(lsu_err_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rdata_i(data_rdata_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .dbg_state_o(dbg_state_o)
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
  endtask

  // Scoreboard for register-file writes
  always @(negedge clk_i) begin
    if (rf_we_o === 1'b1) begin
      if (exp_q.size() == 0) check("rf_we_unexpected", 32'd1, 32'd0);
      else check("sb_rf_wdata", rf_wdata_o, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one request for a single edge; the LSU must be idle.
  task automatic issue(input logic we, input logic [1:0] typ, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    lsu_we_i       = we;
    lsu_type_i     = typ;
    lsu_sign_ext_i = sext;
    lsu_addr_i     = addr;
    lsu_wdata_i    = wdata;
    lsu_rd_i       = rd;
    lsu_req_i      = 1'b1;
    tick();
    lsu_req_i      = 1'b0;
  endtask

  // Grant after gdly idle cycles, then respond on the following cycle.
  task automatic bus(input int gdly, input logic [31:0] rdata, input logic err);
    repeat (gdly) tick();
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i  = rdata;
    data_err_i    = err;
    tick();
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [1:0] typ, input logic sext,
                           input logic [31:0] addr, input logic [4:0] rd,
                           input logic [3:0] exp_be, input logic [31:0] rdata,
                           input logic [31:0] exp_val);
    issue(1'b0, typ, sext, addr, 32'h0, rd);
    check({tag, "_req"}, data_req_o, 1'b1);
    check({tag, "_be"}, data_be_o, exp_be);
    check({tag, "_addr"}, data_addr_o, {addr[31:2], 2'b00});
    exp_q.push_back(exp_val);
    bus(0, rdata, 1'b0);
    check({tag, "_done"}, lsu_done_o, 1'b1);
    check({tag, "_rf_we"}, rf_we_o, 1'b1);
    check({tag, "_rf_waddr"}, rf_waddr_o, rd);
    check({tag, "_rf_wdata"}, rf_wdata_o, exp_val);
    tick();
  endtask

  initial begin
    // Reset
    repeat (2) tick();
    check("rst_ready", lsu_ready_o, 1'b1);
    check("rst_req", data_req_o, 1'b0);
    check("rst_done", lsu_done_o, 1'b0);
    check("rst_rf_we", rf_we_o, 1'b0);
    check("rst_state", dbg_state_o, 2'd0);
    check("rst_rf_wdata", rf_wdata_o, 32'h0);
    rst_ni = 1'b1;
    tick();

    // Word store, grant on the request cycle
    issue(1'b1, 2'b00, 1'b0, 32'h100, 32'hDEADBEEF, 5'd0);
    check("st_req", data_req_o, 1'b1);
    check("st_ready", lsu_ready_o, 1'b0);
    check("st_addr", data_addr_o, 32'h100);
    check("st_we", data_we_o, 1'b1);
    check("st_be", data_be_o, 4'b1111);
    check("st_wdata", data_wdata_o, 32'hDEADBEEF);
    bus(0, 32'h0, 1'b0);
    check("st_done", lsu_done_o, 1'b1);
    check("st_err", lsu_err_o, 1'b0);
    check("st_rf_we", rf_we_o, 1'b0);
    check("st_ready_on_done", lsu_ready_o, 1'b1);
    tick();
    check("st_done_single", lsu_done_o, 1'b0);

    // Loads of each size and extension
    load_case("ld_sb", 2'b10, 1'b1, 32'h203, 5'd5, 4'b1000, 32'h80FFFFFF, 32'hFFFFFF80);
    load_case("ld_uh", 2'b01, 1'b0, 32'h202, 5'd7, 4'b1100, 32'hBEEF1234, 32'h0000BEEF);
    load_case("ld_sh", 2'b01, 1'b1, 32'h300, 5'd8, 4'b0011, 32'h12348001, 32'hFFFF8001);
    load_case("ld_ub", 2'b10, 1'b0, 32'h301, 5'd9, 4'b0010, 32'h0000A500, 32'h000000A5);
    load_case("ld_w", 2'b00, 1'b1, 32'h304, 5'd31, 4'b1111, 32'h12345678, 32'h12345678);

    // Alignment and illegal-type errors
    issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 5'd3);
    check("mis_w_req", data_req_o, 1'b0);
    check("mis_w_done", lsu_done_o, 1'b1);
    check("mis_w_err", lsu_err_o, 1'b1);
    check("mis_w_rf_we", rf_we_o, 1'b0);
    check("mis_w_ready", lsu_ready_o, 1'b1);
    tick();
    check("mis_w_done_single", lsu_done_o, 1'b0);
    issue(1'b1, 2'b01, 1'b0, 32'h203, 32'h0, 5'd0);
    check("mis_h_err", lsu_err_o, 1'b1);
    check("mis_h_req", data_req_o, 1'b0);
    issue(1'b0, 2'b11, 1'b0, 32'h200, 32'h0, 5'd2);
    check("ill_err", lsu_err_o, 1'b1);
    check("ill_req", data_req_o, 1'b0);
    tick();

    // Byte store with a 3-cycle grant stall; inputs wiggle, stray rvalid ignored
    issue(1'b1, 2'b10, 1'b0, 32'h201, 32'h000000AB, 5'd0);
    for (int i = 0; i < 3; i++) begin
      check("hold_req", data_req_o, 1'b1);
      check("hold_addr", data_addr_o, 32'h200);
      check("hold_be", data_be_o, 4'b0010);
      check("hold_wdata", data_wdata_o, 32'h0000AB00);
      check("hold_no_done", lsu_done_o, 1'b0);
      lsu_addr_i    = $urandom;
      lsu_wdata_i   = $urandom;
      data_rvalid_i = (i == 1);
      tick();
    end
    data_rvalid_i = 1'b0;
    check("hold_state", dbg_state_o, 2'd1);
    bus(0, 32'h0, 1'b0);
    check("stall_done", lsu_done_o, 1'b1);
    check("stall_rf_we", rf_we_o, 1'b0);
    tick();

    // Bus error on a load, then a load to x0
    issue(1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 5'd9);
    bus(1, 32'hCAFEF00D, 1'b1);
    check("berr_done", lsu_done_o, 1'b1);
    check("berr_err", lsu_err_o, 1'b1);
    check("berr_rf_we", rf_we_o, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h404, 32'h0, 5'd0);
    bus(0, 32'h55555555, 1'b0);
    check("x0_done", lsu_done_o, 1'b1);
    check("x0_rf_we", rf_we_o, 1'b0);
    tick();

    // Reset while waiting for rvalid, then a late response
    issue(1'b0, 2'b00, 1'b0, 32'h500, 32'h0, 5'd4);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    check("abort_state_before", dbg_state_o, 2'd2);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("abort_state", dbg_state_o, 2'd0);
    check("abort_req", data_req_o, 1'b0);
    check("abort_ready", lsu_ready_o, 1'b1);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h11112222;
    tick();
    data_rvalid_i = 1'b0;
    check("late_rv_done", lsu_done_o, 1'b0);
    check("late_rv_rf_we", rf_we_o, 1'b0);
    tick();
    check("late_rv_done2", lsu_done_o, 1'b0);

`ifdef LSU_TIMEOUT_EN
    // Watchdog: grant never arrives
    issue(1'b0, 2'b00, 1'b0, 32'h600, 32'h0, 5'd6);
    repeat (3) tick();
    check("tmo_not_yet", lsu_done_o, 1'b0);
    check("tmo_req_held", data_req_o, 1'b1);
    tick();
    check("tmo_done", lsu_done_o, 1'b1);
    check("tmo_err", lsu_err_o, 1'b1);
    check("tmo_req", data_req_o, 1'b0);
    data_rvalid_i = 1'b1;
    tick();
    data_rvalid_i = 1'b0;
    check("tmo_stale_done", lsu_done_o, 1'b0);
    check("tmo_stale_rf_we", rf_we_o, 1'b0);
`endif

    tick();
    check("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
